// File: rtl/matvec_sched_pkg.sv
// Shared constants, helper function and FSM encoding for the matrix-vector scheduler.
package matvec_sched_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned FLOAT_WIDTH = 32;
  localparam int unsigned VEC_SIZE    = 4;
  localparam int unsigned DOT_LATENCY = 1 + clog2(VEC_SIZE);
  localparam int unsigned MAX_ROWS    = 8;
  localparam int unsigned ROW_IDX_W   = clog2(MAX_ROWS + 1);
  localparam int unsigned FIFO_DEPTH  = DOT_LATENCY + 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/sched_result_fifo.sv
// Show-ahead result FIFO with occupancy count; a pop frees a slot for a same-cycle push.
module sched_result_fifo #(
  parameter int unsigned Width = 36,
  parameter int unsigned Depth = 5,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [Width-1:0] data_i,
  input  logic            pop_i,
  output logic [Width-1:0] data_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full, do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full && !pop_i));

endmodule

// File: rtl/matvec_sched.sv
// Issues matrix rows into a fixed-latency vec_dot pipeline under FIFO credit and
// collects the tagged results into a valid/ready result stream.
module matvec_sched
  import matvec_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ROW_IDX_W-1:0]   num_rows,
  input  logic                   relu_en,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [ROW_IDX_W-1:0]   rd_addr,
  input  logic [FLOAT_WIDTH-1:0] dot_result,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [FLOAT_WIDTH-1:0] res_data,
  output logic [ROW_IDX_W-1:0]   res_idx,
  output logic                   res_last
);

  localparam int unsigned EntryW   = ROW_IDX_W + FLOAT_WIDTH;
  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CreditW  = clog2(FIFO_DEPTH + DOT_LATENCY + 1);

  state_e                 state_q, state_d;
  logic [ROW_IDX_W-1:0]   num_rows_q, num_rows_d;
  logic [ROW_IDX_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [ROW_IDX_W-1:0]   retire_cnt_q, retire_cnt_d;
  logic                   relu_q, relu_d;
  logic [DOT_LATENCY-1:0] vld_q, vld_d;
  logic [ROW_IDX_W-1:0]   idx_q [DOT_LATENCY];
  logic [ROW_IDX_W-1:0]   idx_d [DOT_LATENCY];

  logic                   fifo_push, fifo_pop, fifo_empty;
  logic [FifoCntW-1:0]    fifo_count;
  logic [EntryW-1:0]      fifo_wdata, fifo_rdata;
  logic [FLOAT_WIDTH-1:0] wr_value;
  logic [CreditW-1:0]     credit_used;

  assign fifo_push  = vld_q[DOT_LATENCY-1];
  assign wr_value   = (relu_q && dot_result[FLOAT_WIDTH-1]) ? '0 : dot_result;
  assign fifo_wdata = {idx_q[DOT_LATENCY-1], wr_value};
  assign fifo_pop   = res_valid && res_ready;

  sched_result_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign res_valid           = !fifo_empty;
  assign {res_idx, res_data} = fifo_rdata;
  assign res_last            = res_valid && (res_idx == num_rows_q - ROW_IDX_W'(1));
  assign busy                = (state_q != StIdle);
  assign rd_addr             = issue_cnt_q;

  // Every row in flight plus every queued result holds a slot, so arrivals never overflow.
  always_comb begin
    credit_used = CreditW'(fifo_count);
    for (int i = 0; i < DOT_LATENCY; i++) credit_used = credit_used + CreditW'(vld_q[i]);
  end

  always_comb begin
    state_d      = state_q;
    num_rows_d   = num_rows_q;
    relu_d       = relu_q;
    issue_cnt_d  = issue_cnt_q;
    retire_cnt_d = retire_cnt_q + ROW_IDX_W'(fifo_pop);
    rd_en        = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_rows_d   = num_rows;
          relu_d       = relu_en;
          issue_cnt_d  = '0;
          retire_cnt_d = '0;
          state_d      = (num_rows == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        rd_en = (credit_used < CreditW'(FIFO_DEPTH));
        if (rd_en) begin
          issue_cnt_d = issue_cnt_q + ROW_IDX_W'(1);
          if (issue_cnt_q == num_rows_q - ROW_IDX_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        // Counting this cycle's pop lets done follow the last pop by exactly one cycle.
        if (retire_cnt_d == num_rows_q) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    vld_d[0] = rd_en;
    idx_d[0] = rd_addr;
    for (int i = 1; i < DOT_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      num_rows_q   <= '0;
      relu_q       <= 1'b0;
      issue_cnt_q  <= '0;
      retire_cnt_q <= '0;
      vld_q        <= '0;
      for (int i = 0; i < DOT_LATENCY; i++) idx_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      num_rows_q   <= num_rows_d;
      relu_q       <= relu_d;
      issue_cnt_q  <= issue_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      vld_q        <= vld_d;
      for (int i = 0; i < DOT_LATENCY; i++) idx_q[i] <= idx_d[i];
    end
  end

endmodule

// File: tb/tb_matvec_sched.sv
// Randomized bench for matvec_sched: a delayed vec_dot model feeds it and a queue of
// expected per-row results, built from the row values, scores the output stream.
module tb_matvec_sched;
  import matvec_sched_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [ROW_IDX_W-1:0]   num_rows = '0;
  logic                   relu_en = 1'b0;
  logic                   busy, done, rd_en, res_valid, res_ready, res_last;
  logic [ROW_IDX_W-1:0]   rd_addr, res_idx;
  logic [FLOAT_WIDTH-1:0] dot_result, res_data;

  matvec_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_rows   (num_rows),
    .relu_en    (relu_en),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .dot_result (dot_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_idx    (res_idx),
    .res_last   (res_last)
  );

  always #5 clk = ~clk;

  // vec_dot model: the value of the row addressed in cycle c appears in cycle c+DOT_LATENCY.
  logic [FLOAT_WIDTH-1:0] row_val [1 << ROW_IDX_W];
  logic [ROW_IDX_W-1:0]   addr_pipe [DOT_LATENCY];
  always @(posedge clk) begin
    addr_pipe[0] <= rd_addr;
    for (int i = 1; i < DOT_LATENCY; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign dot_result = row_val[addr_pipe[DOT_LATENCY-1]];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Consumer: fixed or random ready.
  bit rand_ready = 1'b0;
  bit ready_fix  = 1'b1;
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      res_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  logic [FLOAT_WIDTH-1:0] exp_q [$];
  bit                     mon_en = 1'b0;
  int cur_n, exp_issue, exp_ret;
  int n_issue, n_pop, n_valid, n_busy, n_done;
  int first_issue, last_issue, first_pop, last_pop, done_cyc;
  bit                     hold_q;
  logic [FLOAT_WIDTH-1:0] hold_data;
  logic [ROW_IDX_W-1:0]   hold_idx;
  logic                   hold_last;

  initial forever begin
    logic [FLOAT_WIDTH-1:0] e;
    @(negedge clk);
    if (mon_en) begin
      if (busy) n_busy++;
      if (res_valid) n_valid++;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (rd_en) begin
        check("rd_addr", 64'(rd_addr), 64'(exp_issue));
        if (n_issue == 0) first_issue = cyc;
        last_issue = cyc;
        n_issue++;
        exp_issue++;
      end
      if (hold_q) begin
        check("stall_valid", 64'(res_valid), 64'd1);
        check("stall_data", 64'(res_data), 64'(hold_data));
        check("stall_idx", 64'(res_idx), 64'(hold_idx));
        check("stall_last", 64'(res_last), 64'(hold_last));
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_result", 64'(res_idx), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("res_data", 64'(res_data), 64'(e));
          check("res_idx", 64'(res_idx), 64'(exp_ret));
          check("res_last", 64'(res_last), 64'(exp_ret == cur_n - 1));
        end
        if (n_pop == 0) first_pop = cyc;
        last_pop = cyc;
        n_pop++;
        exp_ret++;
      end
      hold_q    = res_valid && !res_ready;
      hold_data = res_data;
      hold_idx  = res_idx;
      hold_last = res_last;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_rd_en"}, 64'(rd_en), 64'd0);
    check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_res_data"}, 64'(res_data), 64'd0);
    check({tag, "_res_idx"}, 64'(res_idx), 64'd0);
    check({tag, "_res_last"}, 64'(res_last), 64'd0);
  endtask

  task automatic start_job(input int n, input bit relu, input bit rnd_vals);
    if (rnd_vals) for (int r = 0; r < MAX_ROWS; r++) row_val[r] = $urandom();
    exp_q.delete();
    for (int r = 0; r < n; r++) begin
      exp_q.push_back((relu && row_val[r][FLOAT_WIDTH-1]) ? '0 : row_val[r]);
    end
    cur_n = n; exp_issue = 0; exp_ret = 0;
    n_issue = 0; n_pop = 0; n_valid = 0; n_busy = 0; n_done = 0;
    first_issue = 0; last_issue = 0; first_pop = 0; last_pop = 0; done_cyc = 0;
    hold_q = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b1;
    num_rows = ROW_IDX_W'(n);
    relu_en  = relu;
    @(posedge clk);
    #1;
    start    = 1'b0;
    num_rows = ROW_IDX_W'($urandom());
    relu_en  = 1'($urandom());
  endtask

  task automatic finish_job(input int n, input bit timing, input bit poke);
    for (int i = 0; i < 400 && n_done == 0; i++) begin
      @(posedge clk);
      #1;
      if (poke && i == 2 && busy) begin
        start    = 1'b1;
        num_rows = ROW_IDX_W'($urandom_range(1, MAX_ROWS));
        relu_en  = 1'($urandom());
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    check("done_seen", 64'(n_done), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    check("done_single", 64'(n_done), 64'd1);
    check("issued", 64'(n_issue), 64'(n));
    check("retired", 64'(n_pop), 64'(n));
    check("leftover", 64'(exp_q.size()), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    if (n == 0) begin
      check("zero_busy_cycles", 64'(n_busy), 64'd1);
      check("zero_valid_cycles", 64'(n_valid), 64'd0);
    end else if (timing) begin
      check("issue_burst", 64'(last_issue - first_issue), 64'(n - 1));
      check("first_result_lat", 64'(first_pop - first_issue), 64'(DOT_LATENCY + 1));
      check("pop_burst", 64'(last_pop - first_pop), 64'(n - 1));
      check("done_after_last", 64'(done_cyc - last_pop), 64'd1);
    end
  endtask

  task automatic run_job(input int n, input bit relu, input bit rnd_vals, input bit timing,
                         input bit poke);
    start_job(n, relu, rnd_vals);
    finish_job(n, timing, poke);
  endtask

  initial begin
    for (int r = 0; r < (1 << ROW_IDX_W); r++) row_val[r] = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Throughput at full rate.
    ready_fix = 1'b1;
    run_job(4, 1'b0, 1'b1, 1'b1, 1'b0);
    run_job(MAX_ROWS, 1'b0, 1'b1, 1'b1, 1'b0);

    // ReLU on and off with known values.
    row_val[0] = 32'hBF80_0000;
    row_val[1] = 32'h4000_0000;
    run_job(2, 1'b1, 1'b0, 1'b1, 1'b0);
    run_job(2, 1'b0, 1'b0, 1'b1, 1'b0);

    // Empty job, then a job with stray start pulses while busy.
    run_job(0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_job(5, 1'b1, 1'b1, 1'b1, 1'b1);

    // Backpressure: only FIFO_DEPTH rows may be issued while nothing drains.
    ready_fix = 1'b0;
    repeat (2) @(posedge clk);
    start_job(MAX_ROWS, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("bp_issued", 64'(n_issue), 64'(FIFO_DEPTH));
    check("bp_rd_en", 64'(rd_en), 64'd0);
    check("bp_valid", 64'(res_valid), 64'd1);
    check("bp_popped", 64'(n_pop), 64'd0);
    ready_fix = 1'b1;
    finish_job(MAX_ROWS, 1'b0, 1'b0);

    // Asynchronous reset mid-job; the follow-up job must see none of the old rows.
    start_job(4, 1'b0, 1'b1);
    for (int i = 0; i < 50 && n_issue < 2; i++) begin
      @(posedge clk);
      #1;
    end
    check("rst_issue_reached", 64'(n_issue >= 2), 64'd1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midjob_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_job(2, 1'b0, 1'b1, 1'b1, 1'b0);

    // Random jobs, alternating fixed and random consumer readiness.
    for (int j = 0; j < 10; j++) begin
      rand_ready = j[0];
      run_job(int'($urandom_range(0, MAX_ROWS)), 1'($urandom()), 1'b1, !j[0], j == 4);
    end
    rand_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
